alu_op_sched: RTL

- Shares the single 4-bit ALU datapath (add, subtract, compare, AND) between two requesters.
- Sits between the requester blocks and the ALU: arbitrates round-robin, drives the ALU select and operands from registers, waits for the result to settle, captures and packs it, then returns it tagged with the requester id.
- One operation in flight at a time.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_op_sched_rr_arb2.sv | 39 +++
 rtl/alu_op_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation scheduler.
//   - op encodings presented to the ALU select lines {alu_s1, alu_s0}
//   - scheduler FSM state type
//   - pack_result(): folds the raw ALU outputs into the 8-bit response word
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        RESP
    } state_t;

    function automatic logic [7:0] pack_result(
        input logic [1:0] op,
        input logic       carry,
        input logic [3:0] sum,
        input logic       gt,
        input logic       eq,
        input logic       lt,
        input logic [3:0] and_v
    );
        logic [7:0] r;
        r = '0;
        case (op)
            OP_ADD,
            OP_SUB:  r = {3'b000, carry, sum};
            OP_CMP:  r = {5'b00000, gt, eq, lt};
            OP_AND:  r = {4'b0000, and_v};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_op_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request per requester
//   en         : arbitration allowed this cycle (grant is forced to zero otherwise)
//   gnt[1:0]   : combinational one-hot grant, or zero
// When both request, the requester that was not granted last wins. The
// pointer moves only when a grant is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // Last granted requester; reset to 1 so requester 0 has priority first.
    logic last;

    always_comb begin
        gnt = '0;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_op_sched.sv
// alu_op_sched: shares one 4-bit ALU between two requesters.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or zero, IDLE only)
//   req_op*/req_a*/req_b* : per-requester op and operands
//   alu_s1/alu_s0/alu_a/b : registered ALU select and operands
//   alu_sum..alu_and      : raw ALU results
//   resp_valid/resp_ready : response handshake
//   resp_id/resp_data     : requester tag and packed result
// Flow: IDLE (grant + latch) -> SETTLE (SETTLE_CYCLES) -> CAPTURE -> RESP.
module alu_op_sched
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [1:0] req_op0,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_b0,
    input  logic [1:0] req_op1,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b1,
    output logic       alu_s0,
    output logic       alu_s1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_sum,
    input  logic       alu_carry,
    input  logic       alu_gt,
    input  logic       alu_eq,
    input  logic       alu_lt,
    input  logic [3:0] alu_and,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_data
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 7) begin : g_bad_settle
        $error("alu_op_sched: SETTLE_CYCLES must be in 1..7");
    end

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [1:0] gnt;
    logic [2:0] cnt;
    logic [1:0] op_r;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic       id_r;
    logic [7:0] data_r;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (state == IDLE),
        .gnt   (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|gnt) state_nx = SETTLE;
            SETTLE:  if (cnt == 3'd1) state_nx = CAPTURE;
            CAPTURE: state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The operand registers feed the ALU directly, so the ALU inputs only
    // change on a grant and simply hold through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            id_r   <= 1'b0;
            data_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        op_r <= gnt[1] ? req_op1 : req_op0;
                        a_r  <= gnt[1] ? req_a1  : req_a0;
                        b_r  <= gnt[1] ? req_b1  : req_b0;
                        id_r <= gnt[1];
                        cnt  <= SETTLE_LOAD;
                    end
                end
                SETTLE: cnt <= cnt - 3'd1;
                CAPTURE: data_r <= pack_result(op_r, alu_carry, alu_sum,
                                               alu_gt, alu_eq, alu_lt, alu_and);
                default: ;
            endcase
        end
    end

    assign req_ready  = gnt;
    assign alu_s0     = op_r[0];
    assign alu_s1     = op_r[1];
    assign alu_a      = a_r;
    assign alu_b      = b_r;
    assign resp_valid = (state == RESP);
    assign resp_id    = id_r;
    assign resp_data  = data_r;

endmodule
